sync_fifo_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 23 ++
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 tb/tb_sync_fifo_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2, usable in constant expressions (pointer/count widths).
  function automatic int fifo_clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, optional FWFT read,
// occupancy count, almost flags and overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        write_enable,
  input  logic                        read_enable,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [fifo_clog2(DEPTH):0]  count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = fifo_clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AEMPTY_THRESH);

  generate
    if (DATA_WIDTH < 1)
      $error("sync_fifo_param: DATA_WIDTH must be >= 1");
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)
      $error("sync_fifo_param: FWFT must be 0 or 1");
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH)
      $error("sync_fifo_param: AFULL_THRESH out of range");
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1)
      $error("sync_fifo_param: AEMPTY_THRESH out of range");
  endgenerate

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_acc, rd_acc;

  // Acceptance uses the pre-edge flags, so full+rd+wr drops the write
  // and empty+rd+wr drops the read.
  assign wr_acc = write_enable && !full;
  assign rd_acc = read_enable  && !empty;

  assign count        = cnt_q;
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign almost_full  = (cnt_q >= AF_C);

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !reset),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_enable && full;
      underflow <= read_enable && empty;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented combinationally; blanked while empty so the
      // unreset RAM never leaks onto data_out.
      assign data_out = empty ? '0 : ram_rdata;
      assign valid    = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic [1:0]            vld_pipe;

      assign vld_pipe[0] = rd_acc;

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q      <= '0;
          vld_pipe[1] <= 1'b0;
        end else begin
          vld_pipe[1] <= vld_pipe[0];
          if (rd_acc) dout_q <= ram_rdata;
        end
      end

      assign data_out = dout_q;
      assign valid    = vld_pipe[1];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: standard 8x16 instance and FWFT 32x4 instance.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        reset;

  logic [7:0]  a_din, a_dout;
  logic        a_we, a_re, a_valid, a_empty, a_full, a_aempty, a_afull, a_ovf, a_udf;
  logic [4:0]  a_count;

  logic [31:0] b_din, b_dout;
  logic        b_we, b_re, b_valid, b_empty, b_full, b_aempty, b_afull, b_ovf, b_udf;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(a_din), .write_enable(a_we),
    .read_enable(a_re), .data_out(a_dout), .valid(a_valid), .empty(a_empty),
    .full(a_full), .almost_empty(a_aempty), .almost_full(a_afull),
    .count(a_count), .overflow(a_ovf), .underflow(a_udf)
  );

  sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(4), .FWFT(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(b_din), .write_enable(b_we),
    .read_enable(b_re), .data_out(b_dout), .valid(b_valid), .empty(b_empty),
    .full(b_full), .almost_empty(b_aempty), .almost_full(b_afull),
    .count(b_count), .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    // {count, empty, aempty, full, afull, valid, ovf, udf}
    n_checks++;
    if ({a_count, a_empty, a_aempty, a_full, a_afull, a_valid, a_ovf, a_udf} !== {5'd0, 7'b1100000})
      $display("FAIL reset_a_state: got cnt=%0d e=%b ae=%b f=%b af=%b v=%b o=%b u=%b expected cnt=0 e=1 ae=1 others 0",
               a_count, a_empty, a_aempty, a_full, a_afull, a_valid, a_ovf, a_udf);
    else n_pass++;
    n_checks++;
    if (a_dout !== 8'h00) $display("FAIL reset_a_dout: got %h expected 00", a_dout);
    else n_pass++;
    n_checks++;
    if ({b_count, b_empty, b_full, b_valid, b_ovf, b_udf, b_dout} !== {3'd0, 5'b10000, 32'h0})
      $display("FAIL reset_b_state: got cnt=%0d e=%b f=%b v=%b o=%b u=%b d=%h expected cnt=0 e=1 d=0",
               b_count, b_empty, b_full, b_valid, b_ovf, b_udf, b_dout);
    else n_pass++;
  endtask

  task automatic test_single();
    a_we = 1'b1; a_din = 8'hAA;
    step();
    a_we = 1'b0;
    n_checks++;
    if ({a_count, a_empty, a_valid} !== {5'd1, 2'b00})
      $display("FAIL single_write: got cnt=%0d e=%b v=%b expected cnt=1 e=0 v=0", a_count, a_empty, a_valid);
    else n_pass++;
    a_re = 1'b1;
    step();
    a_re = 1'b0;
    n_checks++;
    if ({a_count, a_empty, a_valid, a_dout, a_ovf, a_udf} !== {5'd0, 2'b11, 8'hAA, 2'b00})
      $display("FAIL single_read: got cnt=%0d e=%b v=%b d=%h o=%b u=%b expected cnt=0 e=1 v=1 d=aa o=0 u=0",
               a_count, a_empty, a_valid, a_dout, a_ovf, a_udf);
    else n_pass++;
    step();
    n_checks++;
    if ({a_valid, a_dout} !== {1'b0, 8'hAA})
      $display("FAIL single_hold: got v=%b d=%h expected v=0 d=aa", a_valid, a_dout);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      a_we = 1'b1; a_din = 8'(i);
      step();
      n_checks++;
      if ({a_count, a_afull, a_full, a_aempty} !== {5'(i + 1), (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2)})
        $display("FAIL fill_flags[%0d]: got cnt=%0d af=%b f=%b ae=%b", i, a_count, a_afull, a_full, a_aempty);
      else n_pass++;
    end
    a_din = 8'hFF;
    step();
    a_we = 1'b0;
    n_checks++;
    if ({a_ovf, a_count} !== {1'b1, 5'd16})
      $display("FAIL overflow_pulse: got o=%b cnt=%0d expected o=1 cnt=16", a_ovf, a_count);
    else n_pass++;
    step();
    n_checks++;
    if ({a_ovf, a_count} !== {1'b0, 5'd16})
      $display("FAIL overflow_clear: got o=%b cnt=%0d expected o=0 cnt=16", a_ovf, a_count);
    else n_pass++;
    a_re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if ({a_valid, a_dout, a_count} !== {1'b1, 8'(i), 5'(15 - i)})
        $display("FAIL drain[%0d]: got v=%b d=%h cnt=%0d expected v=1 d=%h cnt=%0d",
                 i, a_valid, a_dout, a_count, 8'(i), 15 - i);
      else n_pass++;
    end
    a_re = 1'b0;
    step();
    n_checks++;
    if ({a_valid, a_empty, a_udf} !== 3'b010)
      $display("FAIL drain_end: got v=%b e=%b u=%b expected v=0 e=1 u=0", a_valid, a_empty, a_udf);
    else n_pass++;
  endtask

  task automatic test_underflow();
    a_re = 1'b1;
    step();
    a_re = 1'b0;
    n_checks++;
    if ({a_udf, a_count, a_valid} !== {1'b1, 5'd0, 1'b0})
      $display("FAIL underflow_pulse: got u=%b cnt=%0d v=%b expected u=1 cnt=0 v=0", a_udf, a_count, a_valid);
    else n_pass++;
    step();
    n_checks++;
    if (a_udf !== 1'b0) $display("FAIL underflow_clear: got u=%b expected 0", a_udf);
    else n_pass++;
    a_we = 1'b1; a_re = 1'b1; a_din = 8'h55;
    step();
    a_we = 1'b0;
    n_checks++;
    if ({a_count, a_udf, a_ovf, a_valid} !== {5'd1, 3'b100})
      $display("FAIL rw_empty: got cnt=%0d u=%b o=%b v=%b expected cnt=1 u=1 o=0 v=0", a_count, a_udf, a_ovf, a_valid);
    else n_pass++;
    step();
    a_re = 1'b0;
    n_checks++;
    if ({a_valid, a_dout, a_count} !== {1'b1, 8'h55, 5'd0})
      $display("FAIL rw_empty_data: got v=%b d=%h cnt=%0d expected v=1 d=55 cnt=0", a_valid, a_dout, a_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    a_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_din = 8'(8'h10 + i);
      step();
    end
    a_re = 1'b1; a_din = 8'hEE;
    step();
    a_we = 1'b0;
    n_checks++;
    if ({a_count, a_ovf, a_valid, a_dout} !== {5'd15, 2'b11, 8'h10})
      $display("FAIL rw_full: got cnt=%0d o=%b v=%b d=%h expected cnt=15 o=1 v=1 d=10", a_count, a_ovf, a_valid, a_dout);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if ({a_dout, a_count} !== {8'(8'h11 + i), 5'(14 - i)})
        $display("FAIL partial_drain[%0d]: got d=%h cnt=%0d expected d=%h cnt=%0d", i, a_dout, a_count, 8'(8'h11 + i), 14 - i);
      else n_pass++;
    end
    // Steady state at count 8: remaining 0x18..0x1F, then the 0x40.. stream.
    a_we = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a_din = 8'(8'h40 + k);
      step();
      exp = (k < 8) ? 8'(8'h18 + k) : 8'(8'h40 + k - 8);
      n_checks++;
      if ({a_valid, a_dout, a_count} !== {1'b1, exp, 5'd8})
        $display("FAIL stream[%0d]: got v=%b d=%h cnt=%0d expected v=1 d=%h cnt=8", k, a_valid, a_dout, a_count, exp);
      else n_pass++;
    end
    a_we = 1'b0; a_re = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_din = 8'(8'h60 + i);
      step();
    end
    n_checks++;
    if (a_count !== 5'd5) $display("FAIL mid_prefill: got cnt=%0d expected 5", a_count);
    else n_pass++;
    reset = 1'b1; a_din = 8'h77;
    step();
    reset = 1'b0; a_we = 1'b0;
    n_checks++;
    if ({a_count, a_empty, a_ovf, a_udf, a_valid} !== {5'd0, 4'b1000})
      $display("FAIL mid_reset: got cnt=%0d e=%b o=%b u=%b v=%b expected cnt=0 e=1 o=0 u=0 v=0",
               a_count, a_empty, a_ovf, a_udf, a_valid);
    else n_pass++;
    a_re = 1'b1;
    step();
    a_re = 1'b0;
    n_checks++;
    if ({a_udf, a_count, a_valid} !== {1'b1, 5'd0, 1'b0})
      $display("FAIL mid_underflow: got u=%b cnt=%0d v=%b expected u=1 cnt=0 v=0", a_udf, a_count, a_valid);
    else n_pass++;
  endtask

  task automatic test_fwft();
    b_we = 1'b1; b_din = 32'hDEADBEEF;
    step();
    b_we = 1'b0;
    n_checks++;
    if ({b_valid, b_dout, b_count} !== {1'b1, 32'hDEADBEEF, 3'd1})
      $display("FAIL fwft_show: got v=%b d=%h cnt=%0d expected v=1 d=deadbeef cnt=1", b_valid, b_dout, b_count);
    else n_pass++;
    step();
    n_checks++;
    if ({b_valid, b_dout} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL fwft_hold: got v=%b d=%h expected v=1 d=deadbeef", b_valid, b_dout);
    else n_pass++;
    b_we = 1'b1; b_din = 32'hCAFEF00D;
    step();
    b_we = 1'b0;
    n_checks++;
    if ({b_dout, b_count, b_afull} !== {32'hDEADBEEF, 3'd2, 1'b1})
      $display("FAIL fwft_second: got d=%h cnt=%0d af=%b expected d=deadbeef cnt=2 af=1", b_dout, b_count, b_afull);
    else n_pass++;
    b_re = 1'b1;
    step();
    n_checks++;
    if ({b_valid, b_dout, b_count} !== {1'b1, 32'hCAFEF00D, 3'd1})
      $display("FAIL fwft_pop1: got v=%b d=%h cnt=%0d expected v=1 d=cafef00d cnt=1", b_valid, b_dout, b_count);
    else n_pass++;
    step();
    b_re = 1'b0;
    n_checks++;
    if ({b_valid, b_empty, b_count, b_udf} !== {2'b01, 3'd0, 1'b0})
      $display("FAIL fwft_pop2: got v=%b e=%b cnt=%0d u=%b expected v=0 e=1 cnt=0 u=0", b_valid, b_empty, b_count, b_udf);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    a_din = '0; a_we = 1'b0; a_re = 1'b0;
    b_din = '0; b_we = 1'b0; b_re = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_fwft();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
